// File: rtl/im_arbiter.sv
// Instruction-ROM read-port arbiter: fetch has fixed priority, debug gets auto-incrementing bursts.
// Optional starvation guard for debug is enabled by defining IM_STARVE_GUARD_EN.
module im_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [3:0]        dbg_len_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i
);

  typedef enum logic {ARB, BURST} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              if_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, dbg_rdata_q;
  logic              burst_beat;
  logic              force_dbg;

`ifdef IM_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  assign force_dbg = (starve_q >= STARVE_TOP);

  always_comb begin
    starve_d = starve_q;
    if (dbg_gnt_o) begin
      starve_d = '0;
    end else if (state_q == ARB && dbg_req_i && starve_q != STARVE_TOP) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Guard compiled out: debug is never forced ahead of fetch.
  assign force_dbg = 1'b0 & (STARVE_MAX == 0);
`endif

  // Combinational outputs are gated by reset so the ROM port is idle while reset is held.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    if_gnt_o   = 1'b0;
    dbg_gnt_o  = 1'b0;
    rom_ce_o   = 1'b0;
    rom_addr_o = '0;
    burst_beat = 1'b0;
    if (rst_ni) begin
      case (state_q)
        ARB: begin
          if (if_req_i && !force_dbg) begin
            if_gnt_o   = 1'b1;
            rom_ce_o   = 1'b1;
            rom_addr_o = if_addr_i;
          end else if (dbg_req_i) begin
            dbg_gnt_o  = 1'b1;
            rom_ce_o   = 1'b1;
            rom_addr_o = dbg_addr_i;
            addr_d     = dbg_addr_i + ADDR_W'(4);
            cnt_d      = dbg_len_i;
            if (dbg_len_i != 4'd0) begin
              state_d = BURST;
            end
          end
        end
        BURST: begin
          burst_beat = 1'b1;
          rom_ce_o   = 1'b1;
          rom_addr_o = addr_q;
          addr_d     = addr_q + ADDR_W'(4);
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB;
      addr_q       <= '0;
      cnt_q        <= '0;
      if_rvalid_q  <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      if_rvalid_q  <= if_gnt_o;
      dbg_rvalid_q <= dbg_gnt_o | burst_beat;
      if (if_gnt_o) begin
        if_rdata_q <= rom_inst_i;
      end
      if (dbg_gnt_o | burst_beat) begin
        dbg_rdata_q <= rom_inst_i;
      end
    end
  end

  assign if_rvalid_o  = if_rvalid_q;
  assign if_rdata_o   = if_rdata_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter with a ROM model and per-requester read-data scoreboards.
module tb_im_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dbg_req;
  logic [31:0] if_addr, dbg_addr;
  logic [3:0]  dbg_len;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, rom_ce;
  logic [31:0] if_rdata, dbg_rdata, rom_addr, rom_inst;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] if_q[$];
  logic [31:0] dbg_q[$];
  logic [31:0] last_if, last_dbg;

`ifdef IM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h3401_1100;
    return (a * 32'd2654435761) ^ 32'h5A5A_1234;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  im_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_len_i(dbg_len),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_inst_i(rom_inst)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check last cycle's read data, then this cycle's grant/ROM port.
  // own: 0 = idle, 1 = fetch access, 2 = debug access.
  task automatic cycle(input logic e_ig, input logic e_dg, input logic e_ce,
                       input logic [31:0] e_addr, input int own);
    @(negedge clk);
    check("if_rvalid", {31'b0, if_rvalid}, {31'b0, (if_q.size() != 0)});
    if (if_q.size() != 0) last_if = if_q.pop_front();
    check("if_rdata", if_rdata, last_if);
    check("dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, (dbg_q.size() != 0)});
    if (dbg_q.size() != 0) last_dbg = dbg_q.pop_front();
    check("dbg_rdata", dbg_rdata, last_dbg);
    check("if_gnt", {31'b0, if_gnt}, {31'b0, e_ig});
    check("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, e_dg});
    check("rom_ce", {31'b0, rom_ce}, {31'b0, e_ce});
    check("rom_addr", rom_addr, e_addr);
    if (own == 1) if_q.push_back(rom_word(e_addr));
    if (own == 2) dbg_q.push_back(rom_word(e_addr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    last_if  = '0;
    last_dbg = '0;
    rst_n    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0010;
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0200;
    dbg_len  = 4'd0;

    // Reset held with both requests active
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    check("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    check("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dbg_rdata", dbg_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    dbg_req = 1'b0;

    // Single fetch then back-to-back fetches
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0010, 1);
    if_addr = 32'h0000_0014;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0014, 1);
    if_addr = 32'h0000_0018;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0018, 1);
    if_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Contention: fetch wins; guard forces debug on the 9th cycle
    if_req   = 1'b1;
    if_addr  = 32'h0000_0100;
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0200;
    dbg_len  = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (GUARD && i == 8) begin
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 2);
        dbg_req = 1'b0;
      end else begin
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0100, 1);
      end
    end
    if_req  = 1'b0;
    dbg_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Wrapping 4-word burst; dbg_req dropped after grant, fetch waits for burst end
    dbg_req  = 1'b1;
    dbg_addr = 32'hFFFF_FFF8;
    dbg_len  = 4'd3;
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 2);
    dbg_req = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0000, 2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0004, 2);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1);
    if_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Single-word debug, fetch granted the following cycle
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0080;
    dbg_len  = 4'd0;
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0080, 2);
    dbg_req = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0044;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0044, 1);
    if_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);

    // Reset in the middle of a 16-word burst
    dbg_req  = 1'b1;
    dbg_addr = 32'h0000_0300;
    dbg_len  = 4'd15;
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300, 2);
    dbg_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0304, 2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0308, 2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_030C, 2);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0310, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("midrst_rom_ce", {31'b0, rom_ce}, 32'd0);
    check("midrst_dbg_rdata", dbg_rdata, 32'd0);
    check("midrst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    if_q.delete();
    dbg_q.delete();
    last_if  = '0;
    last_dbg = '0;
    @(posedge clk);
    #1;
    check("midrst_held_ce", {31'b0, rom_ce}, 32'd0);
    rst_n   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h0000_0020;
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0020, 1);
    if_req = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
